// File: rtl/button_event_scheduler.sv
// Multi-button front end: a round-robin scanner shares one debounce timer across all
// inputs and queues each qualified level change as a press/release event.

module button_event_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic sync
);
    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            sync <= 1'b0;
        end else begin
            meta <= raw;
            sync <= meta;
        end
    end
endmodule

module button_event_scheduler #(
    parameter int NUM_BUTTONS  = 4,
    parameter int DELAY_COUNTS = 2500,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_BUTTONS-1:0]         buttons,
    output logic [NUM_BUTTONS-1:0]         stable,
    output logic                           evt_valid,
    input  logic                           evt_ready,
    output logic [$clog2(NUM_BUTTONS)-1:0] evt_button,
    output logic                           evt_pressed,
    output logic                           overflow,
    input  logic                           clear_overflow
);
    localparam int IDX_W   = $clog2(NUM_BUTTONS);
    localparam int TIMER_W = $clog2(DELAY_COUNTS + 1);
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(DELAY_COUNTS - 1);
    localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(NUM_BUTTONS - 1);

    typedef enum logic [1:0] {SCAN, QUALIFY, COMMIT} state_t;

    typedef struct packed {
        logic [IDX_W-1:0] button;
        logic             pressed;
    } evt_t;

    logic [NUM_BUTTONS-1:0] sync;
    state_t                 state;
    logic [IDX_W-1:0]       idx;
    logic                   candidate;
    logic [TIMER_W-1:0]     timer;

    for (genvar gi = 0; gi < NUM_BUTTONS; gi++) begin : g_sync
        button_event_sync u_sync (
            .clk  (clk),
            .rst_n(rst_n),
            .raw  (buttons[gi]),
            .sync (sync[gi])
        );
    end

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
        return (i == IDX_LAST) ? '0 : i + 1'b1;
    endfunction

    // idx advances after every qualify attempt, so a bouncing input cannot hog the timer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= SCAN;
            idx       <= '0;
            candidate <= 1'b0;
            timer     <= '0;
            stable    <= '0;
        end else begin
            case (state)
                SCAN: begin
                    if (sync[idx] != stable[idx]) begin
                        candidate <= sync[idx];
                        timer     <= '0;
                        state     <= QUALIFY;
                    end else begin
                        idx <= next_idx(idx);
                    end
                end
                QUALIFY: begin
                    if (sync[idx] != candidate) begin
                        idx   <= next_idx(idx);
                        state <= SCAN;
                    end else if (timer == TIMER_LAST) begin
                        state <= COMMIT;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                COMMIT: begin
                    stable[idx] <= candidate;
                    idx         <= next_idx(idx);
                    state       <= SCAN;
                end
                default: state <= SCAN;
            endcase
        end
    end

    logic [PTR_W:0] wr_ptr, rd_ptr;
    evt_t           mem [FIFO_DEPTH];
    evt_t           head;
    logic           push, pop, full, empty, push_ok;

    assign push    = (state == COMMIT);
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                     (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign pop     = !empty && evt_ready;
    // When full, the write slot equals the head slot being popped this same cycle.
    assign push_ok = push && (!full || pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            if (push && !push_ok)   overflow <= 1'b1;
            else if (clear_overflow) overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr[PTR_W-1:0]] <= {idx, candidate};
    end

    assign head        = mem[rd_ptr[PTR_W-1:0]];
    assign evt_valid   = !empty;
    assign evt_button  = evt_valid ? head.button  : '0;
    assign evt_pressed = evt_valid ? head.pressed : 1'b0;
endmodule
